// File: rtl/ex_div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, handshake levels, default width.
package ex_div_unit_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/ex_div_unit_if.sv
// Divider request/result bundle between EX control (master) and the divider (slave).
interface ex_div_unit_if
   import ex_div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) ();

   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/ex_div_unit_step.sv
// One radix-2 restoring step: trial {rem, dividend bit} minus divisor, restore on borrow.
module ex_div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W:0]   trial_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] rem_o,
   output logic              quot_bit_o
);

   logic [DATA_W-1:0] diff;

   // Non-negative difference <=> trial >= divisor; the true difference is then
   // below the divisor, so its low DATA_W bits are exact.
   always_comb begin
      quot_bit_o = (trial_i >= {1'b0, divisor_i});
      diff       = trial_i[DATA_W-1:0] - divisor_i;
      rem_o      = quot_bit_o ? diff : trial_i[DATA_W-1:0];
   end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle signed/unsigned restoring divider for EX; result {remainder, quotient}.
// Operands latched at start; one quotient bit per cycle; annul kills the operation.
module ex_div_unit
   import ex_div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   ex_div_unit_if.slave  div_if
);

   localparam int              CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   div_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     dvd_q, dvd_d;
   logic [DATA_W-1:0]     dvs_q, dvs_d;
   logic [DATA_W-1:0]     rem_q, rem_d;
   logic                  neg_quot_q, neg_quot_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;

   logic                  accept;
   logic                  op1_neg, op2_neg;
   logic [DATA_W-1:0]     op1_mag, op2_mag;
   logic [DATA_W-1:0]     step_rem;
   logic                  step_qbit;
   logic [DATA_W-1:0]     quot_raw, quot_fix, rem_fix;

   assign accept = (state_q == DIV_IDLE) && (div_if.start_i == DIV_START) && !div_if.annul_i;

   // Magnitudes of the operands; the most negative value maps to unsigned 2^(DATA_W-1).
   always_comb begin
      op1_neg = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
      op2_neg = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
      op1_mag = op1_neg ? (-div_if.opdata1_i) : div_if.opdata1_i;
      op2_mag = op2_neg ? (-div_if.opdata2_i) : div_if.opdata2_i;
   end

   ex_div_step #(.DATA_W(DATA_W)) u_step (
      .trial_i    ({rem_q, dvd_q[DATA_W-1]}),
      .divisor_i  (dvs_q),
      .rem_o      (step_rem),
      .quot_bit_o (step_qbit)
   );

   // Quotient bits shift into the vacated low end of the dividend register.
   always_comb begin
      quot_raw = {dvd_q[DATA_W-2:0], step_qbit};
      quot_fix = neg_quot_q ? (-quot_raw) : quot_raw;
      rem_fix  = neg_rem_q  ? (-step_rem) : step_rem;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DIV_IDLE;
         cnt_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= DIV_RESULT_NOT_READY;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         rem_q      <= rem_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: begin
            if (accept)
               state_d = (div_if.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
         end
         DIV_BYZERO: state_d = div_if.annul_i ? DIV_IDLE : DIV_END;
         DIV_ON: begin
            if (div_if.annul_i)
               state_d = DIV_IDLE;
            else if (cnt_q == LAST_ITER)
               state_d = DIV_END;
         end
         DIV_END: begin
            if ((div_if.start_i == DIV_STOP) || div_if.annul_i)
               state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;
      case (state_q)
         DIV_IDLE: begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
            if (accept) begin
               dvd_d      = op1_mag;
               dvs_d      = op2_mag;
               rem_d      = '0;
               cnt_d      = '0;
               neg_quot_d = op1_neg ^ op2_neg;
               neg_rem_d  = op1_neg;
            end
         end
         DIV_BYZERO: begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
         end
         DIV_ON: begin
            if (div_if.annul_i) begin
               cnt_d    = '0;
               result_d = '0;
               ready_d  = DIV_RESULT_NOT_READY;
            end else begin
               rem_d = step_rem;
               dvd_d = quot_raw;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  cnt_d    = '0;
                  result_d = {rem_fix, quot_fix};
                  ready_d  = DIV_RESULT_READY;
               end
            end
         end
         DIV_END: begin
            // Divide-by-zero arrives here with ready low; it is raised on the first END edge.
            if ((div_if.start_i == DIV_STOP) || div_if.annul_i) begin
               result_d = '0;
               ready_d  = DIV_RESULT_NOT_READY;
            end else begin
               ready_d  = DIV_RESULT_READY;
            end
         end
         default: begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
         end
      endcase
   end

   assign div_if.result_o = result_q;
   assign div_if.ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: table of divides plus annul, reset and hold sequences.
module tb_ex_div_unit;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ex_div_unit_if #(.DATA_W(32)) div_if ();

   ex_div_unit #(.DATA_W(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (div_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Called at #1 after a rising edge with the DUT idle; the next edge is the start edge.
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_lat,
                         input bit chg_mid, input string name);
      int n;
      bit seen;
      div_if.signed_div_i = sgn;
      div_if.opdata1_i    = a;
      div_if.opdata2_i    = b;
      div_if.start_i      = 1'b1;
      n    = -1;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (div_if.ready_o) seen = 1'b1;
         else if (chg_mid && n == 5) begin
            div_if.opdata1_i    = 32'h1;
            div_if.opdata2_i    = 32'h1;
            div_if.signed_div_i = ~sgn;
         end
      end
      check({name, " ready seen"}, 64'(seen), 64'd1);
      check({name, " latency"}, 64'(n), 64'(exp_lat));
      check({name, " result"}, div_if.result_o, exp_res);
      @(posedge clk); #1;
      check({name, " result held"}, div_if.result_o, exp_res);
      div_if.start_i = 1'b0;
      @(posedge clk); #1;
      check({name, " ready clear"}, 64'(div_if.ready_o), 64'd0);
      check({name, " result clear"}, div_if.result_o, 64'd0);
   endtask

   task automatic watch_idle(input string name, input int cycles);
      bit rose;
      rose = 1'b0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (div_if.ready_o) rose = 1'b1;
      end
      check(name, 64'(rose), 64'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0]  = '{1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 32};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 32};
      vecs[2]  = '{1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 32};
      vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 32};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 32};
      vecs[5]  = '{1'b0, 32'd12345,     32'd0,         64'h00000000_00000000, 2};
      vecs[6]  = '{1'b1, 32'd9,         32'd3,         64'h00000000_00000003, 32};
      vecs[7]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 32};
      vecs[8]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  64'hFFFFFFFF_00000003, 32};
      vecs[9]  = '{1'b0, 32'hFFFFFFF9,  32'h00000002,  64'h00000001_7FFFFFFC, 32};
      vecs[10] = '{1'b1, 32'h80000000,  32'd0,         64'h00000000_00000000, 2};

      rst                 = 1'b1;
      div_if.signed_div_i = 1'b0;
      div_if.opdata1_i    = '0;
      div_if.opdata2_i    = '0;
      div_if.start_i      = 1'b0;
      div_if.annul_i      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready", 64'(div_if.ready_o), 64'd0);
      check("reset result", div_if.result_o, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++)
         run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat,
                1'b0, $sformatf("vec%0d", i));

      // Divide by zero with start held: END must persist, no restart with new operands.
      begin
         int n;
         bit ok;
         div_if.signed_div_i = 1'b0;
         div_if.opdata1_i    = 32'd55;
         div_if.opdata2_i    = 32'd0;
         div_if.start_i      = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         check("byzero hold ready", 64'(div_if.ready_o), 64'd1);
         div_if.opdata2_i = 32'd5;
         ok = 1'b1;
         for (n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (!div_if.ready_o || div_if.result_o != 64'd0) ok = 1'b0;
         end
         check("byzero hold no restart", 64'(ok), 64'd1);
         div_if.start_i = 1'b0;
         @(posedge clk); #1;
         check("byzero drop ready", 64'(div_if.ready_o), 64'd0);
      end

      // Annul sampled on the edge performing iteration 10.
      div_if.signed_div_i = 1'b0;
      div_if.opdata1_i    = 32'd1000;
      div_if.opdata2_i    = 32'd3;
      div_if.start_i      = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      div_if.start_i = 1'b0;
      div_if.annul_i = 1'b1;
      @(posedge clk); #1;
      div_if.annul_i = 1'b0;
      check("annul ready", 64'(div_if.ready_o), 64'd0);
      watch_idle("annul no ready", 40);
      run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 1'b0, "after annul");

      // Reset asserted during iteration 20.
      div_if.opdata1_i = 32'd100;
      div_if.opdata2_i = 32'd7;
      div_if.start_i   = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midop reset ready", 64'(div_if.ready_o), 64'd0);
      check("midop reset result", div_if.result_o, 64'd0);
      rst            = 1'b0;
      div_if.start_i = 1'b0;
      watch_idle("after reset idle", 40);

      run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 1'b1, "operand change");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage. Supports signed DIV and unsigned DIVU.
- EX control raises start_i and holds it until ready_o. The stage stalls on (start_i && !ready_o).
- The 64-bit result {remainder, quotient} feeds the HI/LO write-selection logic: HI = remainder, LO = quotient.
- Operands are latched at start, so upstream forwarding changes during the operation have no effect.

Parameters:
- DATA_W, 32, operand width. The result is 2*DATA_W wide and the iteration count equals DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  DATA_W  dividend; sampled with start
- opdata2_i  in  DATA_W  divisor; sampled with start
- start_i  in  1  request; held high by EX until ready_o is seen
- annul_i  in  1  flush/exception kill of the in-flight divide
- result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o = 1
- ready_o  out  1  result valid; registered

Behaviour:
- Reset:
  - rst is synchronous and active-high; it overrides everything, including mid-operation.
  - Reset forces state IDLE, counter 0, result_o 0, ready_o 0.
- States: IDLE, BYZERO, ON, END. All outputs are registered.
- IDLE:
  - result_o = 0, ready_o = 0.
  - Edge N with start_i=1 and annul_i=0: latch the operands.
  - If divisor = 0, go to BYZERO. Otherwise go to ON with counter = 0.
  - start_i together with annul_i is ignored; stay in IDLE.
- Operand conditioning:
  - When signed and an operand is negative, use its two's-complement magnitude.
  - The 0x80000000 magnitude is handled as unsigned 2^31, which is correct in 32 bits.
- ON, one iteration per edge:
  - Form the trial value from {partial remainder, next dividend bit}.
  - Subtract the divisor magnitude. If the result is non-negative, the quotient bit is 1 and the remainder takes the difference. Otherwise the quotient bit is 0 and the remainder is restored.
  - Counter increments 0..DATA_W-1. The edge performing iteration DATA_W-1 also writes result_o and ready_o=1 and moves to END.
- ON, annul: annul_i=1 on any ON edge goes to IDLE with result_o=0 and ready_o=0. No result is ever produced for an annulled operation.
- Sign fix-up, applied as the result is registered:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative; the remainder sign follows the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. It wraps; no trap.
- BYZERO: one cycle, then END with result_o = 0. Architecturally undefined, but the value is fixed for verification.
- END:
  - ready_o=1 and result_o is held.
  - When start_i=0, go to IDLE, clearing ready_o and result_o on that edge.
  - annul_i=1 in END also goes to IDLE.
  - While start_i stays high, remain in END; there is no re-trigger.
- Latency, with start sampled at edge N:
  - Nonzero divisor: ready_o is high after edge N+DATA_W (32).
  - Zero divisor: ready_o is high after edge N+2.
- Back-to-back: a new start is accepted only from IDLE, i.e. start_i must drop for at least one cycle between operations.

Decomposition:
- Shared package/defines: state encodings (DIV_IDLE, DIV_BYZERO, DIV_ON, DIV_END); DIV_RESULT_READY/NOT_READY and DIV_START/STOP constants; the DATA_W default.
- One natural sub-module: ex_div_step. It is combinational: it takes {partial remainder, dividend bit} and the divisor, and returns the next remainder and the quotient bit. It is reused if the design moves to radix-4 later.
- Sign conditioning and fix-up stay in the top module.

Test Plan:
- Unsigned 100/7: ready_o rises exactly 32 edges after start; result_o = 0x00000002_0000000E. Drop start: ready_o=0 and result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD. Signed 7/-2: result_o = 0x00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF: result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF / 0x00000001: result_o = 0x00000000_FFFFFFFF.
- Divisor 0 (any dividend): ready_o after 2 edges, result_o = 0. Holding start keeps END; no restart.
- annul_i pulsed at iteration 10: state returns to IDLE, ready_o never rises. A following 9/3 start completes normally with 0x00000000_00000003.
- rst asserted at iteration 20: next edge result_o=0, ready_o=0, IDLE. Changing opdata1_i/opdata2_i mid-operation does not alter the result.
